// File: rtl/stream_latency_buffer_pkg.sv
// stream_latency_buffer_pkg: sizing helpers shared by the latency buffer files.
// Latency: n/a (compile-time functions only).
// Backpressure: n/a.
package stream_latency_buffer_pkg;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer indexing depth entries; at least one bit so a
  // single-entry buffer still has a legal pointer register.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Legal configuration: the pipeline takes at least one cycle and the
  // buffer holds at least one entry.
  function automatic bit cfg_ok(input int unsigned latency, input int unsigned depth);
    return (latency >= 1) && (depth >= 1);
  endfunction

endpackage

// File: rtl/stream_latency_buffer_if.sv
// stream_latency_buffer_if: ready/valid stream carrying a W-bit payload.
// Latency: n/a (wires only).
// Backpressure: the slave holds the master off by keeping ready low.
// Signals: valid/payload driven by the master, ready driven by the slave.
interface stream_latency_buffer_if #(
  parameter int unsigned W = 1
);
  logic         valid;
  logic         ready;
  logic [W-1:0] payload;

  modport master (output valid, output payload, input  ready);
  modport slave  (input  valid, input  payload, output ready);
endinterface

// File: rtl/stream_latency_buffer_mem.sv
// stream_latency_buffer_mem: DEPTH x W storage for the latency buffer.
// Latency: write lands on the clock edge; read is combinational from the address.
// Backpressure: none; the caller decides when to write.
// Ports: clk; wr_en_i/wr_addr_i/wr_dat_i write port; rd_addr_i -> rd_dat_o read port.
module stream_latency_buffer_mem #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 1,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [W-1:0]  wr_dat_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [W-1:0]  rd_dat_o
);

  // Payload storage carries no reset: entries are only read once count
  // says they hold valid data.
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_addr_i];

endmodule

// File: rtl/stream_latency_buffer.sv
// stream_latency_buffer: credit-issuing receive buffer at the tail of a fixed-latency,
//   non-stallable pipeline, re-emitting arrivals as a ready/valid stream.
// Latency: arrival in cycle t is visible on stream_out_o at t+1 at the earliest.
// Backpressure: stream_out_o.ready stalls the output; the head is throttled through
//   issue_ready_o so the unstallable tail never finds the buffer full.
// Ports: clk, rst (async, active-high); issue_valid_i/issue_ready_o head credit handshake;
//   stream_in_i pipeline tail (ready tied high); stream_out_o buffered output;
//   error_o sticky protocol-violation flag.
module stream_latency_buffer
  import stream_latency_buffer_pkg::*;
#(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned DEPTH   = 4,
  parameter type         T       = logic
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  issue_ready_o,
  input  logic                  issue_valid_i,
  stream_latency_buffer_if.slave  stream_in_i,
  stream_latency_buffer_if.master stream_out_o,
  output logic                  error_o
);

  localparam int unsigned CW = cnt_width(DEPTH);
  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned W  = $bits(T);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  if (!cfg_ok(LATENCY, DEPTH)) begin : g_cfg_check
    $error("stream_latency_buffer: LATENCY and DEPTH must both be at least 1");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic          error_q, error_d;

  logic          issue;
  logic          arrival;
  logic          pop;
  logic          orphan;
  logic          overflow;
  logic          accept;
  logic          consume;
  logic          out_vld;
  logic [CW:0]   occupancy;
  T              wr_dat;
  T              rd_dat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  // Credit check uses registered state only, so issue_ready_o has no
  // combinational path from stream_out_o.ready or issue_valid_i.
  assign occupancy     = {1'b0, count_q} + {1'b0, in_flight_q};
  assign issue_ready_o = occupancy < {1'b0, DEPTH_C};

  assign issue   = issue_valid_i && issue_ready_o;
  assign arrival = stream_in_i.valid;
  assign out_vld = (count_q != '0);
  assign pop     = out_vld && stream_out_o.ready;

  // An arrival nobody issued is dropped and leaves in_flight at zero.
  // An arrival into a full buffer with no pop to make room is dropped, but
  // it still matched an issue, so it retires its in-flight credit.
  assign orphan   = arrival && (in_flight_q == '0);
  assign overflow = arrival && (count_q == DEPTH_C) && !pop;
  assign accept   = arrival && !orphan && !overflow;
  assign consume  = arrival && !orphan;

  // The tail cannot stall, so it is always accepted at the port.
  assign stream_in_i.ready = 1'b1;
  assign wr_dat            = stream_in_i.payload;

  always_comb begin
    in_flight_d = in_flight_q + CW'(issue) - CW'(consume);
    count_d     = count_q + CW'(accept) - CW'(pop);
    wr_ptr_d    = accept ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop    ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    error_d     = error_q || orphan || overflow;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_flight_q <= '0;
      error_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      error_q     <= error_d;
    end
  end

  stream_latency_buffer_mem #(
    .DEPTH (DEPTH),
    .W     (W),
    .AW    (PW)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (accept),
    .wr_addr_i (wr_ptr_q),
    .wr_dat_i  (wr_dat),
    .rd_addr_i (rd_ptr_q),
    .rd_dat_o  (rd_dat)
  );

  assign stream_out_o.valid   = out_vld;
  assign stream_out_o.payload = rd_dat;
  assign error_o              = error_q;

endmodule

// File: tb/tb_stream_latency_buffer.sv
// tb_stream_latency_buffer: two buffer instances (A: LATENCY 3 / DEPTH 5, B: LATENCY 3 / DEPTH 2)
// fed by a behavioural fixed-delay pipeline, checked against a transaction-count reference model.
module tb_stream_latency_buffer;

  localparam int L = 3;

  logic clk;
  logic rst;
  logic iv       [2];
  logic rdy      [2];
  logic inj      [2];
  logic rand_pay [2];
  logic exp_err  [2];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = (g == 0) ? 5 : 2;

    stream_latency_buffer_if #(.W(8)) s_in ();
    stream_latency_buffer_if #(.W(8)) s_out ();

    logic dut_rdy;
    logic dut_err;

    stream_latency_buffer #(
      .LATENCY (L),
      .DEPTH   (D),
      .T       (logic [7:0])
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .issue_ready_o (dut_rdy),
      .issue_valid_i (iv[g]),
      .stream_in_i   (s_in),
      .stream_out_o  (s_out),
      .error_o       (dut_err)
    );

    // Behavioural pipeline: pv[k] holds the issue decided k cycles ago.
    logic       pv [0:L];
    logic [7:0] pd [0:L];
    logic [7:0] q [$];
    int issued, arrived, popped, dut_iss, cyc, t_iss1, t_out1;
    logic [7:0] nxt;
    logic exp_rdy, exp_vld, iss;
    string nm;

    assign s_in.valid    = pv[L] | inj[g];
    assign s_in.payload  = inj[g] ? 8'hEE : pd[L];
    assign s_out.ready   = rdy[g];

    always @(negedge clk) begin
      nm = (g == 0) ? "A" : "B";
      cyc++;
      if (rst) begin
        for (int i = 0; i <= L; i++) begin
          pv[i] = 1'b0;
          pd[i] = 8'h00;
        end
        q.delete();
        issued = 0; arrived = 0; popped = 0;
        t_iss1 = -1; t_out1 = -1;
        nxt = 8'h00;
        chk({nm, ".rst_issue_ready"}, dut_rdy, 1);
        chk({nm, ".rst_out_valid"}, s_out.valid, 0);
        chk({nm, ".rst_error"}, dut_err, 0);
      end else begin
        if (pv[L]) arrived++;
        // Credits held = issued but not yet popped; data visible = arrived but not popped.
        exp_rdy = (issued - popped) < D;
        exp_vld = (arrived - popped) > 0;
        chk({nm, ".issue_ready"}, dut_rdy, exp_rdy);
        chk({nm, ".out_valid"}, s_out.valid, exp_vld);
        chk({nm, ".error"}, dut_err, exp_err[g]);
        if (iv[g] && dut_rdy) dut_iss++;
        if (s_out.valid && t_out1 < 0) t_out1 = cyc;
        if (exp_vld) begin
          chk({nm, ".payload"}, s_out.payload, q[0]);
          if (rdy[g]) begin
            void'(q.pop_front());
            popped++;
          end
        end
        iss = iv[g] && exp_rdy;
        for (int i = L; i > 0; i--) begin
          pv[i] = pv[i-1];
          pd[i] = pd[i-1];
        end
        pv[0] = iss;
        pd[0] = nxt;
        if (iss) begin
          q.push_back(nxt);
          issued++;
          if (t_iss1 < 0) t_iss1 = cyc;
          nxt = rand_pay[g] ? 8'($urandom) : nxt + 8'd1;
        end
      end
    end
  end

  task automatic drain();
    int k;
    iv[0] = 1'b0; iv[1] = 1'b0;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    k = 0;
    while (k < 300 && !(g_dut[0].issued == g_dut[0].popped &&
                        g_dut[1].issued == g_dut[1].popped)) begin
      tick();
      k++;
    end
    chk("drain_bounded", k < 300, 1);
  endtask

  task automatic do_reset();
    iv[0] = 1'b0; iv[1] = 1'b0;
    exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    rst = 1'b1;
    tick();
    chk("A.rst_async_ready", g_dut[0].dut_rdy, 1);
    chk("A.rst_async_valid", g_dut[0].s_out.valid, 0);
    chk("A.rst_async_error", g_dut[0].dut_err, 0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      iv[g] = 1'b0; rdy[g] = 1'b1; inj[g] = 1'b0;
      rand_pay[g] = 1'b0; exp_err[g] = 1'b0;
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("A.idle_ready", g_dut[0].dut_rdy, 1);
    chk("A.idle_valid", g_dut[0].s_out.valid, 0);
    chk("B.idle_error", g_dut[1].dut_err, 0);

    // Full throughput on A: payloads 0..99 back to back.
    base = g_dut[0].dut_iss;
    iv[0] = 1'b1;
    repeat (100) tick();
    iv[0] = 1'b0;
    chk("A.thru_issues", g_dut[0].dut_iss - base, 100);
    chk("A.first_out_lat", g_dut[0].t_out1 - g_dut[0].t_iss1, L + 1);
    drain();

    // Backpressure on A: exactly DEPTH credits, recovery one cycle after the first pop.
    base = g_dut[0].dut_iss;
    rdy[0] = 1'b0;
    iv[0] = 1'b1;
    repeat (20) tick();
    chk("A.bp_accepted", g_dut[0].dut_iss - base, 5);
    chk("A.bp_stalled", g_dut[0].dut_rdy, 0);
    chk("A.bp_out_valid", g_dut[0].s_out.valid, 1);
    iv[0] = 1'b0;
    rdy[0] = 1'b1;
    tick();
    chk("A.bp_recover", g_dut[0].dut_rdy, 1);
    drain();

    // Throttling on B: 2 accepted issues per 5 cycles.
    base = g_dut[1].dut_iss;
    iv[1] = 1'b1;
    repeat (50) tick();
    iv[1] = 1'b0;
    chk("B.throttle_issues", g_dut[1].dut_iss - base, 20);
    drain();

    // Random traffic on both, random payloads, at least 1000 transfers through A.
    rand_pay[0] = 1'b1; rand_pay[1] = 1'b1;
    base = g_dut[0].dut_iss;
    for (int k = 0; k < 20000; k++) begin
      for (int g = 0; g < 2; g++) begin
        iv[g]  = ($urandom_range(0, 3) != 0);
        rdy[g] = ($urandom_range(0, 3) != 0);
      end
      tick();
      if (g_dut[0].dut_iss - base >= 1000) break;
    end
    chk("A.rnd_1000_done", (g_dut[0].dut_iss - base) >= 1000, 1);
    drain();

    // Error 1: arrival with nothing in flight.
    inj[0] = 1'b1;
    tick();
    inj[0] = 1'b0;
    exp_err[0] = 1'b1;
    repeat (4) tick();
    chk("A.err_orphan_sticky", g_dut[0].dut_err, 1);
    chk("A.err_orphan_dropped", g_dut[0].s_out.valid, 0);
    do_reset();
    chk("A.err_cleared", g_dut[0].dut_err, 0);

    // Error 2: extra arrival into a full buffer while stalled; stored data must survive.
    rand_pay[0] = 1'b1;
    rdy[0] = 1'b0;
    iv[0] = 1'b1;
    repeat (10) tick();
    iv[0] = 1'b0;
    repeat (5) tick();
    chk("A.full_no_credit", g_dut[0].dut_rdy, 0);
    inj[0] = 1'b1;
    tick();
    inj[0] = 1'b0;
    exp_err[0] = 1'b1;
    tick();
    chk("A.err_overflow", g_dut[0].dut_err, 1);
    drain();
    chk("A.ovf_no_extra", g_dut[0].s_out.valid, 0);
    chk("A.ovf_popped", g_dut[0].popped, 5);

    // Error 3: reset in the middle of a burst clears everything.
    rdy[0] = 1'b0;
    iv[0] = 1'b1;
    repeat (6) tick();
    rdy[0] = 1'b1;
    repeat (2) tick();
    do_reset();
    repeat (8) tick();
    chk("A.mid_rst_ready", g_dut[0].dut_rdy, 1);
    chk("A.mid_rst_valid", g_dut[0].s_out.valid, 0);
    chk("A.mid_rst_error", g_dut[0].dut_err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/stream_latency_buffer.md
# stream_latency_buffer

Receive-end buffer for a fixed-latency, non-stallable pipeline carrying a `stream_intf` payload. It issues credits to the pipeline head through `issue_ready`, so that no more transfers are ever in flight than it can store. It absorbs arrivals at the pipeline tail unconditionally and re-emits them as a backpressured `stream_intf`. It lets compute pipelines whose stages cannot stall sit between ready/valid stream stages.

## Interface
- `CLOCK_INFO`, `'b0`: clock/reset descriptor (`std_clock_info_t`). Reset is asynchronous, active-high.
- `LATENCY`, 1: cycles from an issue handshake at the pipeline head to the matching `stream_in.valid` at the tail; must be ≥ 1.
- `DEPTH`, 4: buffer entries; must be ≥ 1. One transfer per cycle is sustained only if `DEPTH ≥ LATENCY + 2`.
- `T`, `logic`: payload type; `$bits(T)` equals both interface payload widths (static assert).
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `issue_ready` output 1: a credit is available, so the head may launch this cycle.
- `issue_valid` input 1: the head launches a transfer this cycle. It counts only when `issue_ready` is high.
- `stream_in` (`stream_intf.in`), `$bits(T)`: pipeline tail. `ready` is tied high; `valid` and `payload` are sampled every cycle.
- `stream_out` (`stream_intf.out`), `$bits(T)`: buffered output with full ready/valid handshake.
- `error` output 1: sticky protocol-violation flag.

## Operation
- **State:**
  - `count`, 0..DEPTH: entries stored.
  - `in_flight`, 0..DEPTH: issued transfers not yet arrived.
  - Read and write pointers, each modulo DEPTH, wrapping DEPTH−1 → 0.
  - `error`.
  - Counter width is `$clog2(DEPTH+1)`.
- **Credit check:** `issue_ready = (count + in_flight) < DEPTH`. It is computed from registers only, with no combinational path from `stream_out.ready` or `issue_valid`.
- **Issue:** an issue is `issue_valid && issue_ready`. `issue_valid` while `issue_ready` is low is ignored; it is not an error.
- **Arrival:** an arrival is `stream_in.valid`. It writes the payload at the write pointer and advances the write pointer.
- **Pop:** a pop is `stream_out.valid && stream_out.ready`. It advances the read pointer.
- **Output drive:** `stream_out.valid = (count != 0)`. `stream_out.payload` is the entry at the read pointer, driven straight from storage.
- **Counter updates:**
  - `in_flight` next = `in_flight + issue − arrival`.
  - `count` next = `count + arrival − pop`.
  - Any combination of issue, arrival and pop may occur in the same cycle, and all updates are exact.
- **Errors (sticky until reset):**
  - An arrival while `in_flight == 0` sets `error`. The payload is dropped and counters saturate at 0.
  - An arrival while `count == DEPTH` and no pop occurs that cycle sets `error`. The payload is dropped.
- **Reset:** the behaviour of the external pipeline across reset is not defined here.
  - On reset, pointers, `count`, `in_flight` and `error` clear. `issue_ready` therefore resets to 1, and `stream_out.valid` and `error` reset to 0.
  - Reset mid-operation discards stored and in-flight data.
  - Arrivals after reset without a matching post-reset issue flag `error`.

## Timing
- **Issue to output:** an issue at cycle t produces an arrival at t+LATENCY. That payload is visible on `stream_out` at t+LATENCY+1 at the earliest (buffer was empty), or later if entries are queued ahead of it.
- **Credit hold time:** a credit is consumed from the cycle after issue and freed in the cycle after the pop.
- **Throughput:** with `DEPTH = LATENCY + 2` and `stream_out.ready` held high, `issue_ready` stays 1 continuously. For smaller DEPTH the issue rate is throttled to `DEPTH/(LATENCY+2)`.
- **Stall and recovery:** downstream stall drops `issue_ready` once `count + in_flight` reaches DEPTH. `issue_ready` returns 1 in the cycle after the first pop.
- **Ordering:** order is strictly FIFO; no reordering occurs.

## Structure
- **Package:** no new typedefs are needed. The payload type comes from parameter `T`, and the static asserts come from `std_util.svh`.
- **Sub-module:** one natural sub-module, `stream_latency_buffer_mem`. It holds the DEPTH×T storage array, with a synchronous write and an asynchronous read port indexed by pointer.
- **Top level:** counters, pointers, the credit check and error logic stay in the top module. Registers with asynchronous reset follow `CLOCK_INFO`.

## Test plan
- **Reset values:**
  - Stimulus: assert `rst` with `LATENCY=3`, `DEPTH=5`.
  - Required response: `issue_ready=1`, `stream_out.valid=0`, `error=0`; after release, unchanged until the first issue.
- **Full throughput:**
  - Stimulus: `LATENCY=3`, `DEPTH=5`; issue payloads 0..99 back-to-back with `stream_out.ready=1`; the model pipeline delays by 3.
  - Required response: `issue_ready` never drops; outputs 0..99 in order; first output at cycle issue+4.
- **Backpressure:**
  - Stimulus: `LATENCY=3`, `DEPTH=5`; hold `stream_out.ready=0` with continuous `issue_valid`.
  - Required response: exactly 5 issues accepted, then `issue_ready=0`; `count` reaches 5 and no data is lost; `stream_out.ready=1` → `issue_ready=1` on the next cycle.
- **Throttling:**
  - Stimulus: `LATENCY=3`, `DEPTH=2`; issue continuously with `ready=1`.
  - Required response: accepted issue rate is 2 per 5 cycles; no error.
- **Simultaneous events and wrap:**
  - Stimulus: `DEPTH=4`; random `ready`; 1000 transfers crossing the pointer wrap with issue, arrival and pop all in the same cycle.
  - Required response: scoreboard matches; `count + in_flight` never exceeds 4.
- **Protocol errors:**
  - Case 1: inject `stream_in.valid` with `in_flight=0` → `error` sets the next cycle and stays 1.
  - Case 2: inject an extra arrival with `count=DEPTH` and `ready=0` → `error=1` and the stored data is unchanged.
  - Case 3: assert `rst` mid-burst → all state clears, `error=0`.
